// File: rtl/xbuf_pkg.sv
// Shared types and constants for the transmit transfer buffer.
// Contents:
//   slot_state_t   lifecycle of one ping-pong slot
//   fill_state_t   states of the TBM fill engine
//   LINE_W         width of one TBM line (bits)
//   WORD_W         width of one host word (bits)
//   WORDS_PER_LINE host words packed into one TBM line
package xbuf_pkg;

   localparam int LINE_W         = 256;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 8;

   typedef enum logic [1:0] {
      FREE,
      FILLING,
      READY,
      DRAINING
   } slot_state_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } fill_state_t;

endpackage

// File: rtl/txbuf_slot_ram.sv
// One slot of block storage: lines are written whole from TBM and read back
// one 32-bit word at a time by the host.
// Ports:
//   clock    sole clock, rising edge
//   reset    synchronous active-high, clears the read register only
//   we_i     write one full line
//   waddr_i  line index to write
//   wdata_i  line data (256 bits)
//   re_i     read one word into the output register
//   raddr_i  line index to read
//   rword_i  word within the line, word k = bits [32k+31:32k]
//   rdata_o  registered read word, holds its value while re_i is low
module txbuf_slot_ram
   import xbuf_pkg::*;
#(
   parameter int LINES   = 128,
   parameter int LINE_AW = 7
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               we_i,
   input  logic [LINE_AW-1:0] waddr_i,
   input  logic [LINE_W-1:0]  wdata_i,
   input  logic               re_i,
   input  logic [LINE_AW-1:0] raddr_i,
   input  logic [2:0]         rword_i,
   output logic [WORD_W-1:0]  rdata_o
);

   logic [LINE_W-1:0] mem [LINES];
   logic [WORD_W-1:0] rdataQ;
   logic [LINE_W-1:0] readLine;
   logic [7:0]        bitOffset;

   // Storage array is left unreset so it can map onto block RAM.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // Word select happens before the output register, so the host sees
   // exactly one cycle of read latency.
   always_comb begin
      readLine  = mem[raddr_i];
      bitOffset = {rword_i, 5'b00000};
   end

   // Output register holds the last word read until the next read.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdataQ <= '0;
      end else if (re_i) begin
         rdataQ <= readLine[bitOffset +: WORD_W];
      end
   end

   assign rdata_o = rdataQ;

endmodule

// File: rtl/tx_xfer_buffer.sv
// Transmit transfer buffer: the IFQ starts fills that stream one block of
// TBM lines into a free ping-pong slot; the host polls General Read Setup
// for the number of ready slots and then pops the block out word by word.
// Optional build macro TXBUF_PARITY_EN adds the hostdata_parity output
// (even parity of hostdata_out, aligned with hostdata_valid).
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   xfer_buf_select, mread_enable    fill request from the IFQ
//   tbm_address                      TBM line address of the block start
//   xfer_complete, fill_busy         fill done pulse and fill engine status
//   chip_select, write_enable        TBM access strobe, write tied low
//   maddress, mdata_in               TBM line address and returned line data
//   gr_select, gr_read_enable        GRS query strobe
//   gr_out, gr_out_enable            ready slot count and its valid pulse
//   host_select, hread_enable        host pop request
//   hostdata_out, hostdata_valid     popped word and its valid pulse
//   host_underrun                    pop attempted with nothing to drain
module tx_xfer_buffer
   import xbuf_pkg::*;
#(
   parameter int NUM_BUFS    = 2,
   parameter int BLOCK_WORDS = 1024,
   parameter int MEM_LATENCY = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               xfer_buf_select,
   input  logic               mread_enable,
   input  logic [31:0]        tbm_address,
   output logic               xfer_complete,
   output logic               fill_busy,
   output logic               chip_select,
   output logic               write_enable,
   output logic [31:0]        maddress,
   input  logic [LINE_W-1:0]  mdata_in,
   input  logic               gr_select,
   input  logic               gr_read_enable,
   output logic [7:0]         gr_out,
   output logic               gr_out_enable,
   input  logic               host_select,
   input  logic               hread_enable,
   output logic [WORD_W-1:0]  hostdata_out,
   output logic               hostdata_valid,
`ifdef TXBUF_PARITY_EN
   output logic               hostdata_parity,
`endif
   output logic               host_underrun
);

   localparam int LINES   = BLOCK_WORDS / WORDS_PER_LINE;
   localparam int LINE_AW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CNT_W   = $clog2(LINES + 1);
   localparam int WORD_AW = $clog2(BLOCK_WORDS);
   localparam int PTR_W   = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;

   fill_state_t            fillStateQ, fillStateD;
   logic [PTR_W-1:0]       fillPtrQ, fillPtrD;
   logic [PTR_W-1:0]       drainPtrQ, drainPtrD;
   logic [PTR_W-1:0]       rdSelQ, rdSelD;
   logic [31:0]            baseQ, baseD;
   logic [CNT_W-1:0]       issueCntQ, issueCntD;
   logic [CNT_W-1:0]       wrCntQ, wrCntD;
   logic [MEM_LATENCY-1:0] retPipeQ, retPipeD;
   logic [WORD_AW-1:0]     drainWordQ, drainWordD;
   slot_state_t            slotQ [NUM_BUFS];
   slot_state_t            slotD [NUM_BUFS];
   logic                   validQ, underrunQ, grEnQ;
   logic [7:0]             grOutQ, readyCnt;
   logic                   fillAccept, fillDone, retValid, pop, popOk;
   logic [WORD_W-1:0]      ramRdata [NUM_BUFS];

   assign retValid = retPipeQ[MEM_LATENCY-1];
   assign pop      = host_select && hread_enable;
   assign popOk    = pop && (slotQ[drainPtrQ] == READY || slotQ[drainPtrQ] == DRAINING);

   // Fill engine next state. Lines are issued back to back in REQ; returns
   // are counted separately so WAIT ends exactly when the last line lands.
   always_comb begin
      fillStateD = fillStateQ;
      fillPtrD   = fillPtrQ;
      baseD      = baseQ;
      issueCntD  = issueCntQ;
      wrCntD     = wrCntQ;
      fillAccept = 1'b0;
      fillDone   = 1'b0;
      case (fillStateQ)
         IDLE: begin
            if (xfer_buf_select && mread_enable && slotQ[fillPtrQ] == FREE) begin
               fillAccept = 1'b1;
               baseD      = tbm_address;
               issueCntD  = '0;
               wrCntD     = '0;
               fillStateD = REQ;
            end
         end
         REQ: begin
            issueCntD = issueCntQ + CNT_W'(1);
            if (issueCntQ == CNT_W'(LINES - 1)) begin
               fillStateD = WAIT;
            end
         end
         WAIT: begin
            if (retValid && wrCntQ == CNT_W'(LINES - 1)) begin
               fillStateD = DONE;
            end
         end
         DONE: begin
            fillDone   = 1'b1;
            fillPtrD   = (fillPtrQ == PTR_W'(NUM_BUFS - 1)) ? '0 : fillPtrQ + PTR_W'(1);
            fillStateD = IDLE;
         end
         default: fillStateD = IDLE;
      endcase
      if (retValid) begin
         wrCntD = wrCntQ + CNT_W'(1);
      end
   end

   // Return-valid pipeline mirrors the fixed TBM read latency.
   always_comb begin
      retPipeD    = retPipeQ;
      retPipeD[0] = chip_select;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         retPipeD[i] = retPipeQ[i-1];
      end
   end

   // Slot lifecycle and drain pointer. Fill and drain always touch slots in
   // different states, so both updates can land in the same cycle. The fill
   // request looks at slotQ, so a slot freed by this cycle's last pop only
   // becomes acceptable next cycle.
   always_comb begin
      for (int i = 0; i < NUM_BUFS; i++) begin
         slotD[i] = slotQ[i];
      end
      drainPtrD  = drainPtrQ;
      drainWordD = drainWordQ;
      rdSelD     = rdSelQ;
      if (fillAccept) begin
         slotD[fillPtrQ] = FILLING;
      end
      if (fillDone) begin
         slotD[fillPtrQ] = READY;
      end
      if (popOk) begin
         rdSelD = drainPtrQ;
         if (drainWordQ == WORD_AW'(BLOCK_WORDS - 1)) begin
            slotD[drainPtrQ] = FREE;
            drainWordD       = '0;
            drainPtrD        = (drainPtrQ == PTR_W'(NUM_BUFS - 1)) ? '0 : drainPtrQ + PTR_W'(1);
         end else begin
            slotD[drainPtrQ] = DRAINING;
            drainWordD       = drainWordQ + WORD_AW'(1);
         end
      end
   end

   // GRS reports slots that are ready but not yet being drained.
   always_comb begin
      readyCnt = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (slotQ[i] == READY) begin
            readyCnt = readyCnt + 8'd1;
         end
      end
   end

   // All control state; reset abandons any fill or drain in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         fillStateQ <= IDLE;
         fillPtrQ   <= '0;
         drainPtrQ  <= '0;
         rdSelQ     <= '0;
         baseQ      <= '0;
         issueCntQ  <= '0;
         wrCntQ     <= '0;
         retPipeQ   <= '0;
         drainWordQ <= '0;
         validQ     <= 1'b0;
         underrunQ  <= 1'b0;
         grEnQ      <= 1'b0;
         grOutQ     <= '0;
         for (int i = 0; i < NUM_BUFS; i++) begin
            slotQ[i] <= FREE;
         end
      end else begin
         fillStateQ <= fillStateD;
         fillPtrQ   <= fillPtrD;
         drainPtrQ  <= drainPtrD;
         rdSelQ     <= rdSelD;
         baseQ      <= baseD;
         issueCntQ  <= issueCntD;
         wrCntQ     <= wrCntD;
         retPipeQ   <= retPipeD;
         drainWordQ <= drainWordD;
         validQ     <= popOk;
         underrunQ  <= pop && !popOk;
         grEnQ      <= gr_select && gr_read_enable;
         if (gr_select && gr_read_enable) begin
            grOutQ <= readyCnt;
         end
         for (int i = 0; i < NUM_BUFS; i++) begin
            slotQ[i] <= slotD[i];
         end
      end
   end

   // One RAM per slot; only the slot being filled or drained is enabled.
   for (genvar g = 0; g < NUM_BUFS; g++) begin : gSlot
      txbuf_slot_ram #(
         .LINES   (LINES),
         .LINE_AW (LINE_AW)
      ) uRam (
         .clock   (clock),
         .reset   (reset),
         .we_i    (retValid && fillPtrQ == PTR_W'(g)),
         .waddr_i (wrCntQ[LINE_AW-1:0]),
         .wdata_i (mdata_in),
         .re_i    (popOk && drainPtrQ == PTR_W'(g)),
         .raddr_i (LINE_AW'(drainWordQ >> 3)),
         .rword_i (drainWordQ[2:0]),
         .rdata_o (ramRdata[g])
      );
   end

   assign chip_select    = (fillStateQ == REQ);
   assign maddress       = chip_select ? baseQ + 32'(issueCntQ) : 32'd0;
   assign write_enable   = 1'b0;
   assign fill_busy      = (fillStateQ != IDLE);
   assign xfer_complete  = (fillStateQ == DONE);
   assign gr_out         = grOutQ;
   assign gr_out_enable  = grEnQ;
   assign hostdata_out   = ramRdata[rdSelQ];
   assign hostdata_valid = validQ;
   assign host_underrun  = underrunQ;
`ifdef TXBUF_PARITY_EN
   assign hostdata_parity = ^hostdata_out;
`endif

endmodule

// File: tb/tb_tx_xfer_buffer.sv
// Directed bench for tx_xfer_buffer with default parameters (2 slots,
// 1024-word blocks, TBM latency 1). A small TBM model answers each line
// address with that line's offset from 0x100 replicated across all words.
module tb_tx_xfer_buffer;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         xfer_buf_select = 1'b0;
   logic         mread_enable = 1'b0;
   logic [31:0]  tbm_address = '0;
   logic         xfer_complete, fill_busy, chip_select, write_enable;
   logic [31:0]  maddress;
   logic [255:0] mdata_in = '0;
   logic         gr_select = 1'b0;
   logic         gr_read_enable = 1'b0;
   logic [7:0]   gr_out;
   logic         gr_out_enable;
   logic         host_select = 1'b0;
   logic         hread_enable = 1'b0;
   logic [31:0]  hostdata_out;
   logic         hostdata_valid, host_underrun;
`ifdef TXBUF_PARITY_EN
   logic         hostdata_parity;
`endif

   int assertCount = 0;
   int failCount   = 0;

   tx_xfer_buffer dut (
      .clock           (clock),
      .reset           (reset),
      .xfer_buf_select (xfer_buf_select),
      .mread_enable    (mread_enable),
      .tbm_address     (tbm_address),
      .xfer_complete   (xfer_complete),
      .fill_busy       (fill_busy),
      .chip_select     (chip_select),
      .write_enable    (write_enable),
      .maddress        (maddress),
      .mdata_in        (mdata_in),
      .gr_select       (gr_select),
      .gr_read_enable  (gr_read_enable),
      .gr_out          (gr_out),
      .gr_out_enable   (gr_out_enable),
      .host_select     (host_select),
      .hread_enable    (hread_enable),
      .hostdata_out    (hostdata_out),
      .hostdata_valid  (hostdata_valid),
`ifdef TXBUF_PARITY_EN
      .hostdata_parity (hostdata_parity),
`endif
      .host_underrun   (host_underrun)
   );

   always #5 clock = ~clock;

   // TBM model: one cycle of read latency, line n = {8{n}} relative to 0x100.
   always @(posedge clock) begin
      if (chip_select) begin
         mdata_in <= {8{maddress - 32'h100}};
      end
   end

   task automatic test_reset();
      @(negedge clock);
      assertCount++;
      if (chip_select !== 1'b0 || fill_busy !== 1'b0 || xfer_complete !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_fill: cs=%b busy=%b done=%b required 0 0 0", chip_select, fill_busy, xfer_complete);
      end
      assertCount++;
      if (gr_out !== 8'd0 || gr_out_enable !== 1'b0 || maddress !== 32'd0 || write_enable !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_misc: gr_out=%0d gr_en=%b maddr=%h we=%b required 0 0 0 0", gr_out, gr_out_enable, maddress, write_enable);
      end
      assertCount++;
      if (hostdata_valid !== 1'b0 || host_underrun !== 1'b0 || hostdata_out !== 32'd0) begin
         failCount++;
         $display("[TB] FAIL reset_host: valid=%b underrun=%b data=%h required 0 0 0", hostdata_valid, host_underrun, hostdata_out);
      end
   endtask

   task automatic test_fill(input logic [31:0] base);
      int csCount    = 0;
      int addrErr    = 0;
      int donePulses = 0;
      @(posedge clock); #1;
      xfer_buf_select = 1'b1; mread_enable = 1'b1; tbm_address = base;
      @(posedge clock); #1;
      xfer_buf_select = 1'b0; mread_enable = 1'b0; tbm_address = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (chip_select) begin
            if (maddress !== base + 32'(csCount)) addrErr++;
            csCount++;
         end
         if (xfer_complete) donePulses++;
      end
      assertCount++;
      if (csCount != 128) begin
         failCount++;
         $display("[TB] FAIL fill_cs_count base=%h: got %0d required 128", base, csCount);
      end
      assertCount++;
      if (addrErr != 0) begin
         failCount++;
         $display("[TB] FAIL fill_address base=%h: %0d wrong addresses required 0", base, addrErr);
      end
      assertCount++;
      if (donePulses != 1 || fill_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL fill_done base=%h: pulses=%0d busy=%b required 1 0", base, donePulses, fill_busy);
      end
   endtask

   task automatic test_grs(input logic [7:0] expCount);
      @(posedge clock); #1;
      gr_select = 1'b1; gr_read_enable = 1'b1;
      @(posedge clock); #1;
      gr_select = 1'b0; gr_read_enable = 1'b0;
      @(negedge clock);
      assertCount++;
      if (gr_out_enable !== 1'b1 || gr_out !== expCount) begin
         failCount++;
         $display("[TB] FAIL grs_count: en=%b gr_out=%0d required 1 %0d", gr_out_enable, gr_out, expCount);
      end
      @(negedge clock);
      assertCount++;
      if (gr_out_enable !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL grs_pulse: en=%b required 0", gr_out_enable);
      end
   endtask

   task automatic test_ignored_request();
      int activity = 0;
      @(posedge clock); #1;
      xfer_buf_select = 1'b1; mread_enable = 1'b1; tbm_address = 32'h300;
      @(posedge clock); #1;
      xfer_buf_select = 1'b0; mread_enable = 1'b0; tbm_address = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (fill_busy || chip_select || xfer_complete) activity++;
      end
      assertCount++;
      if (activity != 0) begin
         failCount++;
         $display("[TB] FAIL ignored_request: %0d active cycles required 0", activity);
      end
   endtask

   task automatic test_drain(input logic [31:0] offset);
      int          validErr = 0;
      int          dataErr  = 0;
      int          firstBad = -1;
      logic [31:0] badGot   = '0;
      logic [31:0] expWord;
      @(posedge clock); #1;
      host_select = 1'b1; hread_enable = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         @(posedge clock); #1;
         if (i == 1023) begin
            host_select = 1'b0; hread_enable = 1'b0;
         end
         @(negedge clock);
         expWord = offset + 32'(i / 8);
         if (hostdata_valid !== 1'b1) validErr++;
         if (hostdata_out !== expWord) begin
            dataErr++;
            if (firstBad < 0) begin
               firstBad = i;
               badGot   = hostdata_out;
            end
         end
`ifdef TXBUF_PARITY_EN
         if (offset == 32'd0 && (i == 56 || i == 24)) begin
            assertCount++;
            if (hostdata_parity !== (i == 56)) begin
               failCount++;
               $display("[TB] FAIL parity word %0d: got %b required %b", i, hostdata_parity, (i == 56));
            end
         end
`endif
      end
      assertCount++;
      if (validErr != 0) begin
         failCount++;
         $display("[TB] FAIL drain_valid offset=%h: %0d pops without valid required 0", offset, validErr);
      end
      assertCount++;
      if (dataErr != 0) begin
         failCount++;
         $display("[TB] FAIL drain_data offset=%h: %0d bad words, first at %0d got %h required %h", offset, dataErr, firstBad, badGot, offset + 32'(firstBad / 8));
      end
      @(negedge clock);
      assertCount++;
      if (hostdata_valid !== 1'b0 || hostdata_out !== offset + 32'd127) begin
         failCount++;
         $display("[TB] FAIL drain_hold: valid=%b data=%h required 0 %h", hostdata_valid, hostdata_out, offset + 32'd127);
      end
   endtask

   task automatic test_underrun();
      @(posedge clock); #1;
      host_select = 1'b1; hread_enable = 1'b1;
      @(posedge clock); #1;
      host_select = 1'b0; hread_enable = 1'b0;
      @(negedge clock);
      assertCount++;
      if (host_underrun !== 1'b1 || hostdata_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL underrun_pulse: underrun=%b valid=%b required 1 0", host_underrun, hostdata_valid);
      end
      @(negedge clock);
      assertCount++;
      if (host_underrun !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL underrun_width: underrun=%b required 0", host_underrun);
      end
   endtask

   // Pops nine words after an underrun: slot 0 must still be the drain target.
   task automatic test_partial_drain();
      logic [31:0] word0 = '1;
      logic [31:0] word8 = '1;
      @(posedge clock); #1;
      host_select = 1'b1; hread_enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clock); #1;
         if (i == 8) begin
            host_select = 1'b0; hread_enable = 1'b0;
         end
         @(negedge clock);
         if (i == 0) word0 = hostdata_out;
         if (i == 8) word8 = hostdata_out;
      end
      assertCount++;
      if (word0 !== 32'd0 || word8 !== 32'd1) begin
         failCount++;
         $display("[TB] FAIL partial_drain: word0=%h word8=%h required 0 1", word0, word8);
      end
   endtask

   task automatic test_reset_midfill();
      int  budget     = 0;
      int  donePulses = 0;
      @(posedge clock); #1;
      xfer_buf_select = 1'b1; mread_enable = 1'b1; tbm_address = 32'h100;
      @(posedge clock); #1;
      xfer_buf_select = 1'b0; mread_enable = 1'b0; tbm_address = '0;
      @(negedge clock);
      while (!(chip_select && maddress == 32'h128) && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      assertCount++;
      if (budget >= 200) begin
         failCount++;
         $display("[TB] FAIL midfill_reach_line40: cs=%b maddr=%h required 1 00000128", chip_select, maddress);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      assertCount++;
      if (chip_select !== 1'b0 || fill_busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL midfill_abort: cs=%b busy=%b required 0 0", chip_select, fill_busy);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (xfer_complete) donePulses++;
      end
      assertCount++;
      if (donePulses != 0) begin
         failCount++;
         $display("[TB] FAIL midfill_no_complete: pulses=%0d required 0", donePulses);
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      test_reset();
      test_fill(32'h100);
      test_grs(8'd1);
      test_fill(32'h200);
      test_grs(8'd2);
      test_ignored_request();
      test_grs(8'd2);
      test_drain(32'h0);
      test_grs(8'd1);
      test_drain(32'h100);
      test_grs(8'd0);
      test_underrun();
      test_fill(32'h100);
      test_grs(8'd1);
      test_partial_drain();
      test_grs(8'd0);
      test_reset_midfill();
      test_grs(8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
